// File: rtl/mul_share_resp.sv
// Two-port responder for a shared 27x27 unsigned pipelined multiplier.
// Fixed A-over-B arbitration with a starvation override for B; results return tagged to their port.
module mul_share_resp #(
  parameter int W          = 27,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_en,
  input  logic [W-1:0]     a_in_1,
  input  logic [W-1:0]     a_in_2,
  output logic             a_gnt,
  output logic             a_vld,
  output logic [2*W-1:0]   a_out,
  input  logic             b_en,
  input  logic [W-1:0]     b_in_1,
  input  logic [W-1:0]     b_in_2,
  output logic             b_gnt,
  output logic             b_vld,
  output logic [2*W-1:0]   b_out,
  output logic [15:0]      conflict_cnt
);

  localparam int PW = 2 * W;
  localparam int SW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic [15:0]   conflict_q, conflict_d;
  logic          force_b;

  logic          vld_p0;
  logic          tag_p0;
  logic [W-1:0]  op1_p0;
  logic [W-1:0]  op2_p0;

  logic          fin_vld;
  logic          fin_tag;
  logic [PW-1:0] fin_prod;

  logic          a_vld_q, a_vld_d;
  logic          b_vld_q, b_vld_d;
  logic [PW-1:0] a_out_q, a_out_d;
  logic [PW-1:0] b_out_q, b_out_d;

  // Stage 0: arbitration and operand select
  always_comb begin
    force_b  = (starve_q == STARVE_LIM);
    a_gnt    = ~reset & a_en & ~force_b;
    b_gnt    = ~reset & b_en & (~a_en | force_b);
    starve_d = (b_en & ~b_gnt) ? starve_q + 1'b1 : '0;
    conflict_d = conflict_q;
    if (a_en & b_en & (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
    vld_p0 = a_gnt | b_gnt;
    tag_p0 = b_gnt;
    op1_p0 = b_gnt ? b_in_1 : a_in_1;
    op2_p0 = b_gnt ? b_in_2 : a_in_2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= '0;
      conflict_q <= '0;
    end else begin
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  if (LAT == 1) begin : g_lat1
    always_comb begin
      fin_vld  = vld_p0;
      fin_tag  = tag_p0;
      fin_prod = PW'(op1_p0) * PW'(op2_p0);
    end
  end else begin : g_latn
    logic [LAT-1:1] vld_q, vld_d;
    logic [LAT-1:1] tag_q, tag_d;
    logic [W-1:0]   op1_p1_q;
    logic [W-1:0]   op2_p1_q;
    logic [PW-1:0]  prod_p1;

    always_comb begin
      vld_d    = vld_q;
      tag_d    = tag_q;
      vld_d[1] = vld_p0;
      tag_d[1] = tag_p0;
      for (int k = 2; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end

    // Stage 1: operand capture, multiply follows the register
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
      tag_q <= tag_d;
      if (vld_p0) begin
        op1_p1_q <= op1_p0;
        op2_p1_q <= op2_p0;
      end
    end

    assign prod_p1 = PW'(op1_p1_q) * PW'(op2_p1_q);

    if (LAT == 2) begin : g_tail2
      assign fin_prod = prod_p1;
    end else begin : g_tailn
      logic [PW-1:0] prod_q [2:LAT-1];
      logic [PW-1:0] prod_d [2:LAT-1];

      always_comb begin
        prod_d    = prod_q;
        prod_d[2] = prod_p1;
        for (int k = 3; k < LAT; k++) begin
          prod_d[k] = prod_q[k-1];
        end
      end

      // Stages 2..LAT-1: product shift
      always_ff @(posedge clk) begin
        prod_q <= prod_d;
      end

      assign fin_prod = prod_q[LAT-1];
    end

    assign fin_vld = vld_q[LAT-1];
    assign fin_tag = tag_q[LAT-1];
  end

  always_comb begin
    a_vld_d = fin_vld & ~fin_tag;
    b_vld_d = fin_vld & fin_tag;
    a_out_d = a_vld_d ? fin_prod : a_out_q;
    b_out_d = b_vld_d ? fin_prod : b_out_q;
  end

  // Stage LAT: per-port result registers, outputs hold between results
  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_out_q <= '0;
      b_out_q <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
    end
  end

  assign a_vld        = a_vld_q;
  assign b_vld        = b_vld_q;
  assign a_out        = a_out_q;
  assign b_out        = b_out_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mul_share_resp.sv
// Bench for mul_share_resp: cycle-level arbitration model plus an in-order result scoreboard.
module tb_mul_share_resp;
  localparam int W          = 27;
  localparam int LAT        = 2;
  localparam int STARVE_MAX = 3;
  localparam int PW         = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_en, b_en;
  logic [W-1:0]  a_in_1, a_in_2, b_in_1, b_in_2;
  logic          a_gnt, b_gnt, a_vld, b_vld;
  logic [PW-1:0] a_out, b_out;
  logic [15:0]   conflict_cnt;

  always #5 clk = ~clk;

  mul_share_resp #(.W(W), .LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_in_1(a_in_1), .a_in_2(a_in_2),
    .a_gnt(a_gnt), .a_vld(a_vld), .a_out(a_out),
    .b_en(b_en), .b_in_1(b_in_1), .b_in_2(b_in_2),
    .b_gnt(b_gnt), .b_vld(b_vld), .b_out(b_out),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    bit            tag;
    logic [PW-1:0] prod;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            m_starve = 0;
  logic [15:0]   m_conf   = '0;
  logic [PW-1:0] last_a   = '0;
  logic [PW-1:0] last_b   = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] mulx(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] xe, ye;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input bit rst, input bit ae, input logic [W-1:0] a1, input logic [W-1:0] a2,
                      input bit be, input logic [W-1:0] b1, input logic [W-1:0] b2,
                      output bit ga, output bit gb);
    bit   fb, eav, ebv;
    exp_t e;
    reset  = rst;
    a_en   = ae;
    a_in_1 = a1;
    a_in_2 = a2;
    b_en   = be;
    b_in_1 = b1;
    b_in_2 = b2;
    @(negedge clk);
    eav = 1'b0;
    ebv = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.tag) begin
        ebv    = 1'b1;
        last_b = e.prod;
      end else begin
        eav    = 1'b1;
        last_a = e.prod;
      end
    end
    chk("a_vld", a_vld, eav);
    chk("b_vld", b_vld, ebv);
    chk("a_out", a_out, last_a);
    chk("b_out", b_out, last_b);
    chk("conflict_cnt", conflict_cnt, m_conf);
    if (rst) begin
      ga = 1'b0;
      gb = 1'b0;
      sb.delete();
      m_starve = 0;
      m_conf   = '0;
      last_a   = '0;
      last_b   = '0;
    end else begin
      fb = (m_starve == STARVE_MAX);
      ga = ae && !fb;
      gb = be && (!ae || fb);
      if (ga) sb.push_back('{1'b0, mulx(a1, a2), cyc + LAT});
      if (gb) sb.push_back('{1'b1, mulx(b1, b2), cyc + LAT});
      m_starve = (be && !gb) ? m_starve + 1 : 0;
      if (ae && be && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
    end
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ga, gb);
  endtask

  task automatic do_reset();
    bit ga, gb;
    step(1'b1, 1'b1, 27'd1, 27'd1, 1'b1, 27'd1, 27'd1, ga, gb);
  endtask

  initial begin
    bit            ga, gb, ra, rb;
    logic [W-1:0]  ra1, ra2, rb1, rb2;
    reset  = 1'b1;
    a_en   = 1'b0;
    b_en   = 1'b0;
    a_in_1 = '0;
    a_in_2 = '0;
    b_in_1 = '0;
    b_in_2 = '0;
    @(posedge clk);
    #1;

    // Reset state with both requests high: no grants, nothing counted
    do_reset();
    idle(1);

    // Single A request, result held afterwards
    step(1'b0, 1'b1, 27'd3, 27'd5, 1'b0, '0, '0, ga, gb);
    idle(4);

    // Max-operand exactness on B: (2^27-1)^2
    step(1'b0, 1'b0, '0, '0, 1'b1, 27'h7FFFFFF, 27'h7FFFFFF, ga, gb);
    idle(LAT);
    chk("b_max", b_out, 54'h3FFFFFF0000001);
    idle(2);

    // Contention: B forced through on its 4th cycle
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 27'd2, 27'd2, 1'b1, 27'd7, 27'd7, ga, gb);
    chk("conflict5", conflict_cnt, 16'd5);
    idle(4);

    // Alternating grants, in-order return
    step(1'b0, 1'b1, 27'd1, 27'd1, 1'b0, '0, '0, ga, gb);
    step(1'b0, 1'b0, '0, '0, 1'b1, 27'd2, 27'd3, ga, gb);
    step(1'b0, 1'b1, 27'd4, 27'd4, 1'b0, '0, '0, ga, gb);
    idle(4);

    // Reset right after a grant discards it; next request serves normally
    step(1'b0, 1'b1, 27'd9, 27'd9, 1'b0, '0, '0, ga, gb);
    do_reset();
    step(1'b0, 1'b1, 27'd2, 27'd5, 1'b0, '0, '0, ga, gb);
    idle(4);

    // Random requesters that hold until granted
    ra = 1'b0;
    rb = 1'b0;
    ra1 = '0; ra2 = '0; rb1 = '0; rb2 = '0;
    for (int i = 0; i < 300; i++) begin
      if (!ra && $urandom_range(0, 1) == 1) begin
        ra  = 1'b1;
        ra1 = W'($urandom);
        ra2 = W'($urandom);
      end
      if (!rb && $urandom_range(0, 2) != 0) begin
        rb  = 1'b1;
        rb1 = W'($urandom);
        rb2 = W'($urandom);
      end
      step(1'b0, ra, ra1, ra2, rb, rb1, rb2, ga, gb);
      if (ga) ra = 1'b0;
      if (gb) rb = 1'b0;
    end
    idle(4);

    // Conflict counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 27'd3, 27'd3, 1'b1, 27'd6, 27'd6, ga, gb);
    chk("conflict_sat", conflict_cnt, 16'hFFFF);
    idle(LAT + 2);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
